// File: rtl/control_in_pkg.sv
// ============================================================================
// Module : control_in_pkg
// Brief  : Shared constants and width helpers for the control-word stage buffer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package control_in_pkg;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/control_in_stage_buffer_if.sv
// ============================================================================
// Module : control_in_stage_buffer_if
// Brief  : Producer/consumer handshake bundle and status for the stage buffer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface control_in_stage_buffer_if
  import control_in_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = cnt_width(DEPTH);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_is_nop;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, out_is_nop, count, full, empty
  );

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, out_is_nop, count, full, empty
  );

endinterface

`default_nettype wire

// File: rtl/control_in_fifo_mem.sv
// ============================================================================
// Module : control_in_fifo_mem
// Brief  : DEPTH x DATA_W register array, one write port, async read port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module control_in_fifo_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  wire logic              clk,
  input  wire logic              i_we,
  input  wire logic [PTR_W-1:0]  i_waddr,
  input  wire logic [DATA_W-1:0] i_wdata,
  input  wire logic [PTR_W-1:0]  i_raddr,
  output logic      [DATA_W-1:0] o_rdata
);

  // No reset: entry validity is tracked by the owner's occupancy count.
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/control_in_stage_buffer.sv
// ============================================================================
// Module : control_in_stage_buffer
// Brief  : Control-word FIFO with valid/ready, flush, bypass and NOP bubbles.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module control_in_stage_buffer
  import control_in_pkg::*;
#(
  parameter int              DATA_W   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(RV_NOP),
  parameter bit              BYPASS   = 1'b1
) (
  input wire logic                clk,
  input wire logic                rst,
  control_in_stage_buffer_if.slave bus
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_full;
  logic              w_empty;
  logic              w_in_ready;
  logic              w_out_valid;
  logic [DATA_W-1:0] w_out_data;
  logic [DATA_W-1:0] w_mem_rdata;
  logic              w_wr;
  logic              w_rd;
  logic              w_push;
  logic              w_pop;

  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_in_ready = !w_full && !bus.flush && !rst;

  // Bypass only ever applies with nothing stored, so ordering stays FIFO.
  always_comb begin
    w_out_valid = 1'b0;
    w_out_data  = NOP_WORD;
    if (!bus.flush) begin
      if (!w_empty) begin
        w_out_valid = 1'b1;
        w_out_data  = w_mem_rdata;
      end else if (BYPASS && bus.in_valid) begin
        w_out_valid = 1'b1;
        w_out_data  = bus.in_data;
      end
    end
  end

  assign w_wr   = bus.in_valid && w_in_ready;
  assign w_rd   = w_out_valid && bus.out_ready;
  assign w_push = w_wr && !(w_empty && w_rd);
  assign w_pop  = w_rd && !w_empty;

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  control_in_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.in_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_mem_rdata)
  );

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_data   = w_out_data;
  assign bus.out_is_nop = !w_out_valid;
  assign bus.count      = r_count;
  assign bus.full       = w_full;
  assign bus.empty      = w_empty;

endmodule

`default_nettype wire
